// File: rtl/demux4_deserializer_pkg.sv
// Shared constants for the demux4 deserializer: channel count, channel index
// width and the default word width.
package demux4_deserializer_pkg;
  localparam int NUM_CH        = 4;
  localparam int CH_W          = 2;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/demux4_chan_shifter.sv
// One channel's serial-to-parallel shift register and bit counter.
// word_o/done_o present the completed word, including the current bit, in the cycle the last bit arrives.
module demux4_chan_shifter #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] word_o,
  output logic             done_o
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    if (MSB_FIRST) shifted = {shreg_q[WIDTH-2:0], bit_i};
    else           shifted = {bit_i, shreg_q[WIDTH-1:1]};
  end

  assign word_o = shifted;
  assign done_o = en_i && (cnt_q == LAST);

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (done_o) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (en_i) begin
      shreg_d = shifted;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/demux4_deserializer.sv
// Deserializes the four demux output lines into per-channel words and hands
// them downstream through a single-entry valid/ready holding register.
module demux4_deserializer
  import demux4_deserializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] d_in,
  input  logic [CH_W-1:0]   sel,
  input  logic              bit_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic [CH_W-1:0]   out_chan,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NUM_CH-1:0] overflow,
  output logic              glitch_err,
  input  logic              clr_err
);
  logic [WIDTH-1:0]  word_w [NUM_CH];
  logic [NUM_CH-1:0] done_w;
  logic [NUM_CH-1:0] en_w;

  logic [WIDTH-1:0]  data_q, data_d;
  logic [CH_W-1:0]   chan_q, chan_d;
  logic              valid_q, valid_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic              glitch_q, glitch_d;

  logic              sample_bit;
  logic              glitch_now;
  logic              complete;
  logic              reg_free;

  assign sample_bit = d_in[sel];
  assign glitch_now = bit_valid && ((d_in & ~(NUM_CH'(1) << sel)) != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      assign en_w[gi] = bit_valid && (sel == CH_W'(gi));
      demux4_chan_shifter #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
      ) u_shifter (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en_w[gi]),
        .bit_i  (sample_bit),
        .word_o (word_w[gi]),
        .done_o (done_w[gi])
      );
    end
  endgenerate

  // sel is single-valued, so at most one channel completes per cycle.
  assign complete = done_w[sel];
  assign reg_free = !valid_q || out_ready;

  always_comb begin
    data_d   = data_q;
    chan_d   = chan_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    glitch_d = glitch_q;
    if (complete && reg_free) begin
      data_d  = word_w[sel];
      chan_d  = sel;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
    if (clr_err) begin
      ovf_d    = '0;
      glitch_d = 1'b0;
    end
    // Setting after clearing lets a same-cycle error event win over clr_err.
    if (complete && !reg_free) ovf_d[sel] = 1'b1;
    if (glitch_now)            glitch_d   = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      chan_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= '0;
      glitch_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      chan_q   <= chan_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      glitch_q <= glitch_d;
    end
  end

  assign out_data   = data_q;
  assign out_chan   = chan_q;
  assign out_valid  = valid_q;
  assign overflow   = ovf_q;
  assign glitch_err = glitch_q;
endmodule

// File: tb/tb_demux4_deserializer.sv
// Scoreboard bench: stimulus pushes expected {chan,data}; a negedge monitor
// pops and compares on each accepted word.
module tb_demux4_deserializer;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d_in;
  logic [1:0] sel;
  logic       bit_valid;
  logic [7:0] out_data;
  logic [1:0] out_chan;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] overflow;
  logic       glitch_err;
  logic       clr_err;

  int total_checks = 0;
  int pass_checks  = 0;
  int idle_valid   = 0;
  logic [9:0] exp_q [$];

  demux4_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .d_in       (d_in),
    .sel        (sel),
    .bit_valid  (bit_valid),
    .out_data   (out_data),
    .out_chan   (out_chan),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .glitch_err (glitch_err),
    .clr_err    (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act === exp) begin
      pass_checks++;
      $display("check %s: got 0x%0h", name, act);
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a word is transferred on the next rising edge when valid && ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {22'd0, out_chan, out_data}, 32'hFFFF_FFFF);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("word", {22'd0, out_chan, out_data}, {22'd0, e});
      end
    end
  end

  task automatic send_bit(input logic [1:0] ch, input logic b);
    sel       = ch;
    d_in      = 4'(b) << ch;
    bit_valid = 1'b1;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    d_in      = 4'b0000;
  endtask

  task automatic send_word(input logic [1:0] ch, input logic [7:0] data, input bit push);
    for (int i = 7; i >= 0; i--) send_bit(ch, data[i]);
    if (push) exp_q.push_back({ch, data});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [7:0] w3c, wf0, w77;
    rst = 1'b1; d_in = '0; sel = '0; bit_valid = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
    w3c = 8'h3C; wf0 = 8'hF0; w77 = 8'h77;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_chan", 32'(out_chan), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_glitch", 32'(glitch_err), 32'd0);

    // Idle: no strobes, out_valid must never assert.
    out_ready = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) idle_valid++;
    end
    check("idle_no_valid", 32'(idle_valid), 32'd0);

    // Single channel, latency 1 from the final strobe.
    for (int i = 7; i >= 1; i--) send_bit(2'd2, 8'hA5 >> i);
    check("a5_not_early", 32'(out_valid), 32'd0);
    send_bit(2'd2, 1'b1);
    exp_q.push_back({2'd2, 8'hA5});
    check("a5_latency", 32'(out_valid), 32'd1);
    idle(2);

    // Interleaved channels 0 and 3.
    for (int i = 7; i >= 0; i--) begin
      send_bit(2'd0, w3c[i]);
      if (i == 0) exp_q.push_back({2'd0, 8'h3C});
      send_bit(2'd3, wf0[i]);
    end
    exp_q.push_back({2'd3, 8'hF0});
    idle(3);
    check("interleave_overflow", 32'(overflow), 32'd0);

    // Backpressure: second ch1 word is dropped.
    out_ready = 1'b0;
    send_word(2'd1, 8'h11, 1'b1);
    send_word(2'd1, 8'h22, 1'b0);
    idle(2);
    check("bp_hold_data", 32'(out_data), 32'h11);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_overflow", 32'(overflow), 32'b0010);
    out_ready = 1'b1;
    idle(1);
    check("bp_valid_fall", 32'(out_valid), 32'd0);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    check("clr_overflow", 32'(overflow), 32'd0);

    // Accept and complete on the same edge: no bubble.
    out_ready = 1'b0;
    send_word(2'd1, 8'h11, 1'b1);
    for (int i = 7; i >= 1; i--) send_bit(2'd0, w77[i]);
    check("acc_pre_data", 32'(out_data), 32'h11);
    out_ready = 1'b1;
    send_bit(2'd0, w77[0]);
    exp_q.push_back({2'd0, 8'h77});
    check("acc_valid_stays", 32'(out_valid), 32'd1);
    check("acc_new_data", 32'(out_data), 32'h77);
    check("acc_no_overflow", 32'(overflow), 32'd0);
    idle(2);

    // Glitch: ch0 selected while line 2 is also high.
    sel = 2'd0; d_in = 4'b0101; bit_valid = 1'b1;
    idle(1);
    bit_valid = 1'b0; d_in = 4'b0000;
    check("glitch_set", 32'(glitch_err), 32'd1);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    check("glitch_clr", 32'(glitch_err), 32'd0);

    // Partial word then reset: only the post-reset word may appear.
    for (int i = 0; i < 5; i++) send_bit(2'd0, 1'b1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check("midrst_valid", 32'(out_valid), 32'd0);
    send_word(2'd0, 8'h5A, 1'b1);
    check("post_rst_data", 32'(out_data), 32'h5A);

    for (int n = 0; n < 50 && exp_q.size() != 0; n++) idle(1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    idle(2);
    check("final_valid_low", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end
endmodule

// File: doc/demux4_deserializer.md
Name: demux4_deserializer

Overview:
- Sits directly downstream of the 1-to-4 gate-level demultiplexer. It consumes the four demux output lines plus the select pair that drove them.
- It treats each output line as an independent serial bit stream and assembles per-channel words.
- It hands completed words, tagged with their channel number, to the next stage over a valid/ready interface.
- It is the first clocked stage after the combinational demux.

Parameters:
- WIDTH, 8, bits per assembled word; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in out_data[WIDTH-1]; 0 = first received bit lands in out_data[0].

Ports:
- clk  input  1  single system clock; all state is updated on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- d_in  input  4  demux outputs {D3,D2,D1,D0}.
- sel  input  2  select pair {A,B} that drove the demux this cycle.
- bit_valid  input  1  sample strobe; d_in/sel are meaningful only when high.
- out_data  output  WIDTH  completed word.
- out_chan  output  2  channel index of out_data.
- out_valid  output  1  word available.
- out_ready  input  1  downstream accepts the word.
- overflow  output  4  sticky per-channel "word dropped" flags.
- glitch_err  output  1  sticky flag: a non-selected demux line was high during a sample.
- clr_err  input  1  synchronous clear of overflow and glitch_err.

Behaviour:
- Reset (asynchronous, immediate on rst high):
  - all four shift registers = 0; all four bit counters = 0.
  - out_data = 0, out_chan = 0, out_valid = 0, overflow = 4'b0000, glitch_err = 0.
- Sampling (rising edge with bit_valid = 1):
  - bit = d_in[sel].
  - Channel sel's shift register takes the bit:
    - MSB_FIRST = 1: shifts left, bit enters the LSB.
    - MSB_FIRST = 0: shifts right, bit enters the MSB.
  - cnt[sel] increments.
  - The other three channels hold their state.
- Glitch check: when bit_valid = 1 and any d_in bit other than d_in[sel] is 1, glitch_err is set (sticky). The sample itself is still taken.
- Word completion: bit_valid = 1 and cnt[sel] == WIDTH-1.
  - The assembled word, including the current bit, is complete.
  - cnt[sel] returns to 0 and shreg[sel] clears to 0 for the next word.
- Output holding register (single entry):
  - The register is free when out_valid == 0, or when out_valid == 1 and out_ready == 1 in the same cycle.
  - On completion with the register free: out_data = word and out_chan = sel on that edge, out_valid = 1 after the edge. Latency is 1 clock from the final bit's edge to out_valid.
  - On completion with the register not free: the word is dropped, overflow[sel] is set, and the held output is unchanged.
  - Handshake: out_valid stays high and out_data/out_chan stay stable until a cycle with out_ready = 1. out_valid drops after that edge unless a new completion loads the register in the same edge.
  - Simultaneous accept and completion: the new word is loaded and out_valid stays 1 with no bubble.
- Only one channel can complete per cycle, because sel is single-valued, so no arbitration is needed.
- bit_valid = 0: no counter or shift-register change. The output handshake still proceeds.
- Error clearing:
  - clr_err = 1 clears overflow and glitch_err on that edge.
  - If a new error event occurs in the same cycle, the set wins.
- Reset mid-word: partial words are discarded and no partial word is emitted.
- Counter width: clog2(WIDTH) bits, wrapping only via the completion rule.

Decomposition:
- Shared include/package holds:
  - the channel count constant NUM_CH = 4;
  - the channel index width CH_W = 2;
  - the default WIDTH.
- One natural sub-module: demux4_chan_shifter. It holds one channel's shift register, bit counter and completion pulse, and is instantiated four times with enable = bit_valid & (sel == i).
- The top level holds the glitch check, the output register and the sticky flags.

Test Plan:
- Reset then idle: rst pulse, bit_valid = 0 for 20 cycles -> all outputs 0, out_valid never asserted.
- Single channel, MSB_FIRST = 1, WIDTH = 8: sel = 2, d_in[2] carries 1,0,1,0,0,1,0,1 on 8 strobes, out_ready = 1 -> out_valid one cycle after the 8th strobe, out_data = 8'hA5, out_chan = 2.
- Interleaved channels: alternate sel = 0 (bits of 8'h3C) and sel = 3 (bits of 8'hF0) on 16 strobes -> two words in order: {chan 0, 8'h3C} then {chan 3, 8'hF0}; overflow stays 0.
- Backpressure: out_ready = 0, complete a word on ch1 (8'h11), then complete a word on ch1 (8'h22) -> out_data holds 8'h11, overflow = 4'b0010. Raise out_ready -> 8'h11 accepted, out_valid falls.
- Accept and complete in the same cycle: out_valid = 1 with 8'h11 and out_ready = 1 on the edge where a ch0 word 8'h77 completes -> out_valid stays 1 and out_data = 8'h77 the next cycle.
- Glitch and reset mid-word: sel = 0 with d_in = 4'b0101 -> glitch_err = 1. Send 5 bits on ch0, assert rst, then send a full 8-bit word -> only the post-reset word appears; clr_err clears glitch_err.
